instr_fetch: RTL and testbench

//  Fetch stage directly downstream of the program counter. Samples PCaddr, runs one

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_timeout_ctr.sv | 37 +++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 tb/tb_instr_fetch.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } fetch_state_t;

  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Clear/enable cycle counter for the fetch request timeout.
// tc flags the last cycle the request may stay outstanding.
module fetch_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one imem request/ack per PC, one iready pulse per word.
// Misaligned PC or memory timeout raises a sticky fault and stops fetching.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] PCaddr,
  input  logic        halt,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        iready,
  output logic        fetch_fault
);

  fetch_state_t state_q;
  fetch_state_t state_d;

  logic        req_q;
  logic        req_d;
  logic [31:0] addr_q;
  logic [31:0] addr_d;
  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic        iready_q;
  logic        iready_d;
  logic        fault_q;
  logic        fault_d;

  logic ctr_clr;
  logic ctr_en;
  logic ctr_tc;

  logic can_start;
  logic misaligned;

  assign can_start  = !fault_q && !halt;
  assign misaligned = (PCaddr[1:0] != 2'b00);

  fetch_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk(clk),
    .rst(RST),
    .clr(ctr_clr),
    .en (ctr_en),
    .tc (ctr_tc)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (can_start && !misaligned) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          state_d = DONE;
        end else if (ctr_tc) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack is checked before the terminal count so a last-cycle ack wins.
  always_comb begin
    req_d    = req_q;
    addr_d   = addr_q;
    instr_d  = instr_q;
    iready_d = 1'b0;
    fault_d  = fault_q;
    ctr_clr  = 1'b0;
    ctr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_start) begin
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            addr_d  = PCaddr;
            req_d   = 1'b1;
            ctr_clr = 1'b1;
          end
        end
      end
      REQ: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          req_d    = 1'b0;
          iready_d = 1'b1;
        end else if (ctr_tc) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      req_q    <= 1'b0;
      addr_q   <= '0;
      instr_q  <= NOP_INSTR;
      iready_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      req_q    <= req_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      iready_q <= iready_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign iready      = iready_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: random memory latency and data,
// PC model advancing on iready, timeout / misalign / halt / reset cases.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        RST;
  logic [31:0] PCaddr;
  logic        halt;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        iready;
  logic        fetch_fault;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   prev_iready = 1'b0;

  instr_fetch #(
    .TIMEOUT  (TIMEOUT),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .PCaddr     (PCaddr),
    .halt       (halt),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .instr      (instr),
    .iready     (iready),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every iready pulse must match the oldest acked fetch.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (iready) begin
      chk("iready_not_back_to_back", 32'(prev_iready), 0);
      chk("iready_with_fault", 32'(fetch_fault), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL iready_spurious: got pulse expected none");
      end else begin
        e = sb.pop_front();
        chk("instr", instr, e.data);
        chk("iready_addr", imem_addr, e.addr);
      end
    end
    prev_iready = iready;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    RST      = 1'b1;
    imem_ack = 1'b0;
    halt     = 1'b0;
    cyc();
    cyc();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_iready", 32'(iready), 0);
    chk("rst_instr", instr, NOP);
    chk("rst_fault", 32'(fetch_fault), 0);
    chk("rst_addr", imem_addr, 0);
    sb.delete();
    RST = 1'b0;
  endtask

  task automatic wait_req();
    for (int k = 0; k < 8 && !imem_req; k++) cyc();
    chk("req_start", 32'(imem_req), 1);
  endtask

  task automatic fetch_one(input int dly, input logic [31:0] data,
                           input bit hmid);
    exp_t e;
    wait_req();
    if (!imem_req) return;
    chk("imem_addr", imem_addr, PCaddr);
    for (int w = 0; w <= dly; w++) begin
      chk("req_held", 32'(imem_req), 1);
      chk("addr_stable", imem_addr, PCaddr);
      if (hmid && w == 0) halt = 1'b1;
      if (w == dly) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
        e.addr     = PCaddr;
        e.data     = data;
        sb.push_back(e);
      end
      cyc();
    end
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    chk("iready_pulse", 32'(iready), 1);
    chk("req_drop", 32'(imem_req), 0);
    chk("no_fault", 32'(fetch_fault), 0);
    PCaddr = PCaddr + 32'd4;
    if (hmid) begin
      repeat (4) begin
        cyc();
        chk("halt_no_req", 32'(imem_req), 0);
      end
      halt = 1'b0;
    end
  endtask

  task automatic timeout_run();
    int n;
    wait_req();
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      cyc();
    end
    chk("timeout_len", n, TIMEOUT);
    chk("timeout_fault", 32'(fetch_fault), 1);
    repeat (6) begin
      cyc();
      chk("fault_no_req", 32'(imem_req), 0);
      chk("fault_sticky", 32'(fetch_fault), 1);
    end
  endtask

  task automatic misalign_run(input logic [1:0] lo);
    PCaddr = {PCaddr[31:2], lo};
    for (int k = 0; k < 4 && !fetch_fault; k++) begin
      cyc();
      chk("misalign_no_req", 32'(imem_req), 0);
    end
    chk("misalign_fault", 32'(fetch_fault), 1);
    repeat (4) begin
      cyc();
      chk("misalign_idle", 32'(imem_req), 0);
    end
  endtask

  task automatic reset_mid_req();
    wait_req();
    cyc();
    RST  = 1'b1;
    halt = 1'b1;
    cyc();
    chk("rstmid_req", 32'(imem_req), 0);
    RST        = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hdead_beef;
    repeat (3) begin
      cyc();
      chk("late_ack_instr", instr, NOP);
      chk("late_ack_req", 32'(imem_req), 0);
      chk("late_ack_iready", 32'(iready), 0);
    end
    imem_ack = 1'b0;
    halt     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST        = 1'b1;
    halt       = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    PCaddr     = 32'h100;
    do_reset();

    fetch_one(0, 32'h0050_0093, 1'b0);
    fetch_one(3, 32'h1234_5678, 1'b0);
    fetch_one(TIMEOUT - 1, 32'hcafe_f00d, 1'b0);

    halt = 1'b1;
    repeat (6) begin
      cyc();
      chk("halt_idle", 32'(imem_req), 0);
    end
    halt = 1'b0;
    fetch_one(1, 32'h0badc0de, 1'b1);
    fetch_one(0, 32'h0000_0073, 1'b0);
    timeout_run();

    PCaddr = 32'h200;
    do_reset();
    reset_mid_req();

    PCaddr = 32'h102;
    do_reset();
    misalign_run(2'b10);

    repeat (8) begin
      int n;
      PCaddr = $urandom & 32'hffff_fffc;
      do_reset();
      n = $urandom_range(3, 8);
      for (int i = 0; i < n; i++) begin
        int d;
        d = ($urandom_range(0, 3) == 0) ? $urandom_range(4, TIMEOUT - 1)
                                        : $urandom_range(0, 3);
        fetch_one(d, $urandom, ($urandom_range(0, 4) == 0));
      end
      if ($urandom_range(0, 1) == 0) begin
        timeout_run();
      end else begin
        misalign_run(2'($urandom_range(1, 3)));
      end
    end

    cyc();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
